// File: rtl/div_pkg.sv
// Shared types and constants for the shift-subtract divider.
// DIV_SIGNED_EN selects the two's-complement build, which adds the FIXUP state.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH = 8;

  // One extra bit so the counter can reach WIDTH without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/div_control.sv
// Divider sequencer: state register, iteration counter and datapath strobes.
// DIV_SIGNED_EN inserts FIXUP between the last iteration and DONE.
//
// state | meaning
// IDLE  | waiting for Start; load operands when it is seen
// CALC  | one shift-subtract iteration per clock
// FIXUP | apply result signs (signed build only)
// DONE  | results held until Start is released
module div_control
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic load,
  output logic step,
`ifdef DIV_SIGNED_EN
  output logic fixup,
`endif
  output logic finish,
  output logic busy,
  output logic done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= CALC;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
`ifdef DIV_SIGNED_EN
            state <= FIXUP;
`else
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
`endif
          end
        end
        FIXUP: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign load = (state == IDLE) && start;
  assign step = (state == CALC);
`ifdef DIV_SIGNED_EN
  assign fixup  = (state == FIXUP);
  assign finish = (state == FIXUP);
`else
  assign finish = (state == CALC) && (cnt == LAST);
`endif

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: one shift-subtract iteration per clock.
// Define DIV_SIGNED_EN for two's-complement operands (one extra FIXUP cycle).
module shift_sub_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  logic load, step, finish;
  logic [WIDTH-1:0] q_w, r_w, d_w;
  logic             dz_w;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] q_next, r_next;

  div_control #(.WIDTH(WIDTH)) u_ctrl (
    .clk    (Clk),
    .rst_n  (Reset),
    .start  (Start),
    .load   (load),
    .step   (step),
`ifdef DIV_SIGNED_EN
    .fixup  (),
`endif
    .finish (finish),
    .busy   (Busy),
    .done   (Done)
  );

  // Shifted remainder keeps its carry-out bit so divisors above 2^(WIDTH-1)
  // still divide correctly; the borrow lands in the extra top bit.
  assign r_sh   = {r_w, q_w[WIDTH-1]};
  assign trial  = {1'b0, r_sh} - {2'b00, d_w};
  assign q_next = {q_w[WIDTH-2:0], ~trial[WIDTH+1]};
  assign r_next = trial[WIDTH+1] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
  logic sign_a, sign_b;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      q_w <= '0; r_w <= '0; d_w <= '0; dz_w <= 1'b0;
      sign_a <= 1'b0; sign_b <= 1'b0;
      Quotient <= '0; Remainder <= '0; DivByZero <= 1'b0;
    end else begin
      if (load) begin
        q_w    <= Dividend[WIDTH-1] ? -Dividend : Dividend;
        d_w    <= Divisor[WIDTH-1]  ? -Divisor  : Divisor;
        r_w    <= '0;
        dz_w   <= (Divisor == '0);
        sign_a <= Dividend[WIDTH-1];
        sign_b <= Divisor[WIDTH-1];
      end
      if (step) begin
        q_w <= q_next;
        r_w <= r_next;
      end
      if (finish) begin
        Quotient  <= dz_w ? '1 : ((sign_a ^ sign_b) ? -q_w : q_w);
        Remainder <= sign_a ? -r_w : r_w;
        DivByZero <= dz_w;
      end
    end
  end
`else
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      q_w <= '0; r_w <= '0; d_w <= '0; dz_w <= 1'b0;
      Quotient <= '0; Remainder <= '0; DivByZero <= 1'b0;
    end else begin
      if (load) begin
        q_w  <= Dividend;
        d_w  <= Divisor;
        r_w  <= '0;
        dz_w <= (Divisor == '0);
      end
      if (step) begin
        q_w <= q_next;
        r_w <= r_next;
      end
      // The final iteration and the result load happen on the same edge.
      if (finish) begin
        Quotient  <= q_next;
        Remainder <= r_next;
        DivByZero <= dz_w;
      end
    end
  end
`endif

endmodule
